// File: rtl/uadd_pkg.sv
// Package: uadd_pkg
// Shared definitions for the unary adder sequencer: the sequencer state
// encoding, default operand/count widths and the drain timeout constant.
package uadd_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_READ   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int OPW_DEF     = 8;
  localparam int CNT_W_DEF   = 9;
  localparam int TIMEOUT_DEF = 2 ** CNT_W_DEF;

  // Number of drained pulses after which a still-high dout means the adder
  // is stuck (a correct adder can never hold more than 2**cnt_w - 1).
  function automatic int timeout_cnt(input int cnt_w);
    return 2 ** cnt_w;
  endfunction

endpackage

// File: rtl/uadd_pulse_gen.sv
// Module: uadd_pulse_gen
// Loadable down-counter that turns a binary operand into a unary pulse
// stream: pulse_o is high while the count is nonzero, and each step_i
// consumes one unit.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load_i     load val_i into the counter
//   val_i      operand value (OPW bits)
//   step_i     consume one unit if nonzero
//   pulse_o    count is nonzero
module uadd_pulse_gen #(
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [OPW-1:0] val_i,
  input  logic           step_i,
  output logic           pulse_o
);

  logic [OPW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (step_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - OPW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/unary_add_seq.sv
// Module: unary_add_seq
// Sequencer that is the sole driver of one unary accumulate/drain adder.
// It accepts a binary operand pair, streams both operands into the adder as
// unary pulses (write mode), then drains the adder (read mode) and counts the
// dout pulses back into a binary result.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   op_valid/op_ready     operand handshake, op_a/op_b binary operands
//   res_valid/res_ready   result handshake, result held until accepted
//   res_sum               drained count (saturates to all-ones on timeout)
//   res_carry             adder carry sampled after the load phase
//   res_err               drain timeout (adder dout stuck high)
//   ua_A/ua_B/ua_en/ua_rw outputs to the adder, ua_dout/ua_C from it
// Optional build macro UNARY_ADD_SEQ_CHECK_EN adds output res_mismatch,
// high in DONE when the drained count differs from the binary a+b or on
// timeout.
module unary_add_seq
  import uadd_pkg::*;
#(
  parameter int OPW    = OPW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OPW-1:0]   op_a,
  input  logic [OPW-1:0]   op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_sum,
  output logic             res_carry,
  output logic             res_err,
`ifdef UNARY_ADD_SEQ_CHECK_EN
  output logic             res_mismatch,
`endif
  output logic             ua_A,
  output logic             ua_B,
  output logic             ua_en,
  output logic             ua_rw,
  input  logic             ua_dout,
  input  logic             ua_C
);

  localparam int LAT_W = $clog2(RD_LAT + 2);
  localparam logic [CNT_W:0] TIMEOUT = (CNT_W + 1)'(timeout_cnt(CNT_W));

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [CNT_W:0]   rd_cnt_q, rd_cnt_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             load_op;
  logic             step_op;
  logic             pulse_a, pulse_b;

  uadd_pulse_gen #(.OPW(OPW)) u_gen_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_op),
    .val_i   (op_a),
    .step_i  (step_op),
    .pulse_o (pulse_a)
  );

  uadd_pulse_gen #(.OPW(OPW)) u_gen_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_op),
    .val_i   (op_b),
    .step_i  (step_op),
    .pulse_o (pulse_b)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    rd_cnt_d  = rd_cnt_q;
    carry_d   = carry_q;
    err_d     = err_q;
    load_op   = 1'b0;
    step_op   = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    ua_A      = 1'b0;
    ua_B      = 1'b0;
    ua_en     = 1'b0;
    ua_rw     = 1'b0;
    unique case (state_q)
      ST_FLUSH: begin
        // Drain whatever count survived a mid-operation reset; dout must be
        // seen low for RD_LAT+1 consecutive cycles so a pulse still in the
        // read pipeline is not mistaken for an empty adder.
        ua_en = 1'b1;
        ua_rw = 1'b1;
        if (ua_dout) begin
          lat_d = '0;
        end else if (lat_q == LAT_W'(RD_LAT)) begin
          lat_d   = '0;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          load_op  = 1'b1;
          rd_cnt_d = '0;
          carry_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Exit on the first cycle both generators are empty, so a=b=0 still
        // spends exactly one LOAD cycle with no pulses.
        ua_en   = 1'b1;
        ua_A    = pulse_a;
        ua_B    = pulse_b;
        step_op = 1'b1;
        if (!pulse_a && !pulse_b) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        ua_en   = 1'b1;
        carry_d = ua_C;
        lat_d   = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        ua_en = 1'b1;
        ua_rw = 1'b1;
        if (lat_q != LAT_W'(RD_LAT)) begin
          lat_d = lat_q + LAT_W'(1);
        end else if (ua_dout) begin
          if (rd_cnt_q == TIMEOUT) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + (CNT_W + 1)'(1);
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FLUSH;
      lat_q    <= '0;
      rd_cnt_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      rd_cnt_q <= rd_cnt_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  // rd_cnt only sets its top bit on timeout; report all-ones then.
  assign res_sum   = rd_cnt_q[CNT_W] ? '1 : rd_cnt_q[CNT_W-1:0];
  assign res_carry = carry_q;
  assign res_err   = err_q;

`ifdef UNARY_ADD_SEQ_CHECK_EN
  logic [CNT_W:0] exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    if (load_op) begin
      exp_d = (CNT_W + 1)'(op_a) + (CNT_W + 1)'(op_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign res_mismatch = (state_q == ST_DONE) && (err_q || (rd_cnt_q != exp_q));
`endif

endmodule
